// File: rtl/arcade_input_pkg.sv
// Shared constants and types for the arcade input controller: PS/2 key codes,
// the button record and the coin-shaping state encoding.
package arcade_input_pkg;

    // 9-bit key codes are {extended, scan code}. Code 0 is reserved as "no key".
    localparam logic [8:0] KEY_UP       = 9'h075;
    localparam logic [8:0] KEY_DOWN     = 9'h072;
    localparam logic [8:0] KEY_LEFT     = 9'h06B;
    localparam logic [8:0] KEY_RIGHT    = 9'h074;
    localparam logic [8:0] KEY_START2_A = 9'h029;
    localparam logic [8:0] KEY_START2_B = 9'h006;
    localparam logic [8:0] KEY_START1_A = 9'h014;
    localparam logic [8:0] KEY_START1_B = 9'h005;
    localparam logic [8:0] KEY_COIN     = 9'h004;

    localparam logic [7:0] PS2_BREAK    = 8'hF0;
    localparam logic [7:0] PS2_EXTENDED = 8'hE0;

    typedef enum logic [1:0] {
        COIN_IDLE    = 2'd0,
        COIN_PULSE   = 2'd1,
        COIN_HOLDOFF = 2'd2
    } coin_state_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic start1;
        logic start2;
        logic coin;
    } buttons_t;

    // Cursor keys exist in both plain and E0-prefixed forms; only the scan code matters.
    function automatic logic scan_match(input logic [8:0] code, input logic [8:0] key);
        return code[7:0] == key[7:0];
    endfunction

endpackage

// File: rtl/arcade_input_ctrl_coin_pulse.sv
// Coin shaper: one fixed-length coin pulse per rising edge of the raw coin
// request, followed by an equal-length hold-off during which new edges are ignored.
module coin_pulse
    import arcade_input_pkg::*;
#(
    parameter logic [19:0] COIN_TICKS = 20'd600000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic ce_6m,
    input  logic coin_raw,
    output logic coin
);

    coin_state_t state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic        raw_q;
    logic        raw_prev_q;
    logic        raw_rise;
    logic        phase_done;

    assign raw_rise   = raw_q & ~raw_prev_q;
    assign phase_done = ce_6m && (cnt_q == COIN_TICKS - 20'd1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= COIN_IDLE;
            cnt_q      <= '0;
            raw_q      <= 1'b0;
            raw_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            raw_q      <= coin_raw;
            raw_prev_q <= raw_q;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        coin    = 1'b0;
        unique case (state_q)
            COIN_IDLE: begin
                if (raw_rise) begin
                    state_d = COIN_PULSE;
                    cnt_d   = '0;
                end
            end
            COIN_PULSE: begin
                coin = 1'b1;
                if (phase_done) begin
                    state_d = COIN_HOLDOFF;
                    cnt_d   = '0;
                end else if (ce_6m) begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            COIN_HOLDOFF: begin
                if (phase_done) begin
                    state_d = COIN_IDLE;
                    cnt_d   = '0;
                end else if (ce_6m) begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            default: begin
                state_d = COIN_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Arcade input controller: merges PS/2 keys and two joysticks into active-low
// IN0/IN1 port bytes. Define COIN_PULSE_EN to shape coin into timed pulses.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter logic [19:0] COIN_TICKS = 20'd600000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_6m,
    input  logic [64:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        orient,
    output logic [7:0]  in0_reg,
    output logic [7:0]  in1_reg
);

    logic        key_toggle_q;
    logic        key_event;
    logic        pressed;
    logic        extended;
    logic [8:0]  key_code;
    buttons_t    btn_q;
    logic [15:0] joy;
    logic        dir_up, dir_down, dir_left, dir_right;
    logic        start1, start2;
    logic        coin_raw;
    logic        coin;
    logic        unused_cfg;

    // The toggle copy also follows the live bit during reset, so leaving reset
    // never looks like a fresh key event.
    always_ff @(posedge clk_sys) begin
        key_toggle_q <= ps2_key[64];
    end

    assign key_event = key_toggle_q != ps2_key[64];
    assign pressed   = ps2_key[15:8] != PS2_BREAK;
    assign extended  = pressed ? (ps2_key[15:8] == PS2_EXTENDED)
                               : (ps2_key[23:16] == PS2_EXTENDED);
    // Longer multi-byte sequences are not ours; collapse them to the no-key code.
    assign key_code  = (|ps2_key[63:24]) ? 9'd0 : {extended, ps2_key[7:0]};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            btn_q <= '0;
        end else if (key_event) begin
            if (scan_match(key_code, KEY_UP))    btn_q.up    <= pressed;
            if (scan_match(key_code, KEY_DOWN))  btn_q.down  <= pressed;
            if (scan_match(key_code, KEY_LEFT))  btn_q.left  <= pressed;
            if (scan_match(key_code, KEY_RIGHT)) btn_q.right <= pressed;
            if (key_code == KEY_START2_A || key_code == KEY_START2_B) btn_q.start2 <= pressed;
            if (key_code == KEY_START1_A || key_code == KEY_START1_B) btn_q.start1 <= pressed;
            if (key_code == KEY_COIN) btn_q.coin <= pressed;
        end
    end

    assign joy = joystick_0 | joystick_1;

    // Horizontal cabinets rotate the stick a quarter turn.
    always_comb begin
        dir_up    = btn_q.up    | joy[3];
        dir_down  = btn_q.down  | joy[2];
        dir_left  = btn_q.left  | joy[1];
        dir_right = btn_q.right | joy[0];
        if (orient) begin
            dir_up    = btn_q.left  | joy[1];
            dir_down  = btn_q.right | joy[0];
            dir_left  = btn_q.down  | joy[2];
            dir_right = btn_q.up    | joy[3];
        end
    end

    assign start1   = btn_q.start1 | joy[4];
    assign start2   = btn_q.start2 | joy[5];
    assign coin_raw = btn_q.coin   | joy[6];

`ifdef COIN_PULSE_EN
    coin_pulse #(
        .COIN_TICKS (COIN_TICKS)
    ) u_coin_pulse (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ce_6m    (ce_6m),
        .coin_raw (coin_raw),
        .coin     (coin)
    );
`else
    assign coin = coin_raw;
`endif

    // Tick enable and tick count only matter to the coin shaper; high joystick bits are spare.
    assign unused_cfg = ^{ce_6m, COIN_TICKS, joy[15:7]};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            in0_reg <= 8'hFF;
            in1_reg <= 8'hFF;
        end else begin
            in0_reg <= ~{2'b00, coin, 1'b0, dir_down, dir_right, dir_left, dir_up};
            in1_reg <= ~{1'b0, start2, start1, 5'b00000};
        end
    end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Scoreboard bench for arcade_input_ctrl: stimulus queues expected port bytes,
// a monitor pops one entry on every output change. Honours COIN_PULSE_EN.
`timescale 1ns/1ps
module tb_arcade_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ce_6m;
    logic [64:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        orient;
    logic [7:0]  in0_reg;
    logic [7:0]  in1_reg;

    always #5 clk_sys = ~clk_sys;

    arcade_input_ctrl #(
        .COIN_TICKS (20'd4)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ce_6m      (ce_6m),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .orient     (orient),
        .in0_reg    (in0_reg),
        .in1_reg    (in1_reg)
    );

    typedef struct {
        string      name;
        logic [7:0] in0;
        logic [7:0] in1;
        int         due;
        int         ticks;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   ce_div = 0;
    logic mon_en = 1'b0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // ce_6m is high one cycle in three
    initial begin
        ce_6m = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            ce_div = (ce_div == 2) ? 0 : ce_div + 1;
            ce_6m  = (ce_div == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // lat < 0 skips the arrival-cycle check; tk < 0 skips the ce-tick count check
    task automatic expect_out(input string name, input logic [7:0] i0, input logic [7:0] i1,
                              input int lat, input int tk);
        exp_t e;
        e.name  = name;
        e.in0   = i0;
        e.in1   = i1;
        e.due   = (lat >= 0) ? cyc + lat : -1;
        e.ticks = tk;
        sb_q.push_back(e);
    endtask

    task automatic send_key(input logic [63:0] body);
        ps2_key = {~ps2_key[64], body};
    endtask

    task automatic wait_coin(input string name, input logic level);
        int n;
        n = 0;
        while (in0_reg[5] !== level && n < 100) begin
            tick(1);
            n++;
        end
        if (n >= 100) check({name, "_timeout"}, {31'h0, in0_reg[5]}, {31'h0, level});
    endtask

    // Monitor: every change of {in0_reg,in1_reg} consumes one scoreboard entry.
    initial begin
        logic [31:0] cur;
        logic [31:0] last_out;
        exp_t        e;
        int          ticks;
        logic        ce_prev;
        last_out = 32'h0000FFFF;
        ticks    = 0;
        ce_prev  = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (mon_en) begin
                cur = {16'h0, in0_reg, in1_reg};
                if (cur !== last_out) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_change", cur, last_out);
                    end else begin
                        e = sb_q.pop_front();
                        check({e.name, "_val"}, cur, {16'h0, e.in0, e.in1});
                        if (e.due >= 0)   check({e.name, "_cycle"}, cyc, e.due);
                        if (e.ticks >= 0) check({e.name, "_ticks"}, ticks, e.ticks);
                    end
                    ticks    = 0;
                    last_out = cur;
                end
                if (ce_prev) ticks++;
            end
            ce_prev = ce_6m;
        end
    end

    initial begin
        int n;
        reset      = 1'b1;
        ps2_key    = {1'b1, 40'h0, 8'h00, 8'h00, 8'h75};
        joystick_0 = '0;
        joystick_1 = '0;
        orient     = 1'b0;
        tick(4);
        reset = 1'b0;
        tick(3);
        check("reset_in0", {24'h0, in0_reg}, 32'hFF);
        check("reset_in1", {24'h0, in1_reg}, 32'hFF);
        mon_en = 1'b1;

        // keyboard directions, plain and extended
        send_key({40'h0, 8'h00, 8'h00, 8'h75}); expect_out("up_press",      8'hFE, 8'hFF, 2, -1); tick(5);
        send_key({40'h0, 8'h00, 8'hF0, 8'h75}); expect_out("up_release",    8'hFF, 8'hFF, 2, -1); tick(5);
        send_key({40'h0, 8'h00, 8'hE0, 8'h75}); expect_out("ext_up_press",  8'hFE, 8'hFF, 2, -1); tick(5);
        send_key({40'h0, 8'hE0, 8'hF0, 8'h75}); expect_out("ext_up_release",8'hFF, 8'hFF, 2, -1); tick(5);

        // body changes without a toggle, long sequences and E0 14 must not fire
        ps2_key[63:0] = {40'h0, 8'h00, 8'h00, 8'h05}; tick(6);
        send_key({40'h1, 8'h00, 8'h00, 8'h05}); tick(6);
        send_key({40'h0, 8'h00, 8'h00, 8'h05}); expect_out("start1_press",  8'hFF, 8'hDF, 2, -1); tick(5);
        send_key({40'h0, 8'h00, 8'hF0, 8'h05}); expect_out("start1_release",8'hFF, 8'hFF, 2, -1); tick(5);
        send_key({40'h0, 8'h00, 8'hE0, 8'h14}); tick(6);
        send_key({40'h0, 8'h00, 8'h00, 8'h29}); expect_out("start2_press",  8'hFF, 8'hBF, 2, -1); tick(5);
        send_key({40'h0, 8'h00, 8'hF0, 8'h29}); expect_out("start2_release",8'hFF, 8'hFF, 2, -1); tick(5);

        // orientation remap, joystick path
        orient = 1'b1; joystick_0 = 16'h0002; expect_out("orient1_joy_left", 8'hFE, 8'hFF, 1, -1); tick(4);
        orient = 1'b0;                        expect_out("orient0_joy_left", 8'hFD, 8'hFF, 1, -1); tick(4);
        joystick_0 = '0;                      expect_out("joy_left_off",     8'hFF, 8'hFF, 1, -1); tick(4);
        orient = 1'b1;
        send_key({40'h0, 8'h00, 8'h00, 8'h72}); expect_out("orient1_key_down", 8'hFD, 8'hFF, 2, -1); tick(5);
        send_key({40'h0, 8'h00, 8'hF0, 8'h72}); expect_out("orient1_down_rel", 8'hFF, 8'hFF, 2, -1); tick(5);
        orient = 1'b0; tick(3);
        joystick_1 = 16'h0010; expect_out("joy1_start1",     8'hFF, 8'hDF, 1, -1); tick(4);
        joystick_1 = '0;       expect_out("joy1_start1_off", 8'hFF, 8'hFF, 1, -1); tick(4);

`ifdef COIN_PULSE_EN
        joystick_0 = 16'h0040;
        expect_out("coin_start", 8'hDF, 8'hFF, 3, -1);
        expect_out("coin_end",   8'hFF, 8'hFF, -1, 4);
        wait_coin("coin_start", 1'b0);
        wait_coin("coin_end", 1'b1);
        joystick_0 = '0; tick(1); joystick_0 = 16'h0040;
        tick(40);
        joystick_0 = '0; tick(20);
        joystick_0 = 16'h0040;
        expect_out("coin_retrig_start", 8'hDF, 8'hFF, 3, -1);
        expect_out("coin_retrig_end",   8'hFF, 8'hFF, -1, 4);
        wait_coin("coin_retrig_start", 1'b0);
        wait_coin("coin_retrig_end", 1'b1);
        joystick_0 = '0; tick(30);
`else
        joystick_0 = 16'h0040; expect_out("coin_raw_on",  8'hDF, 8'hFF, 1, -1); tick(4);
        joystick_0 = '0;       expect_out("coin_raw_off", 8'hFF, 8'hFF, 1, -1); tick(4);
`endif

        // reset with a key held and coin active
        send_key({40'h0, 8'h00, 8'h00, 8'h75}); expect_out("up_before_reset", 8'hFE, 8'hFF, 2, -1); tick(5);
        joystick_0 = 16'h0040;
`ifdef COIN_PULSE_EN
        expect_out("coin_before_reset", 8'hDE, 8'hFF, 3, -1); tick(5);
`else
        expect_out("coin_before_reset", 8'hDE, 8'hFF, 1, -1); tick(3);
`endif
        reset = 1'b1; joystick_0 = '0;
        expect_out("reset_mid_pulse", 8'hFF, 8'hFF, 1, -1);
        tick(1);
        reset = 1'b0;
        tick(20);
        send_key({40'h0, 8'h00, 8'h00, 8'h75}); expect_out("up_after_reset", 8'hFE, 8'hFF, 2, -1); tick(5);
        send_key({40'h0, 8'h00, 8'hF0, 8'h75}); expect_out("up_rel_after_reset", 8'hFF, 8'hFF, 2, -1); tick(5);

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        check("scoreboard_drained", sb_q.size(), 0);
        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/arcade_input_ctrl.md
ARCADE_INPUT_CTRL -- requirements
Module: arcade_input_ctrl

Interface
REQ-001 SHALL have parameter COIN_TICKS, default 20'd600000: ce_6m ticks per coin pulse phase, 100 ms.
REQ-002 SHALL have port clk_sys, input, 1: system clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port ce_6m, input, 1: 6 MHz clock enable, one clk_sys cycle wide.
REQ-005 SHALL have port ps2_key, input, 65: hps_io key record; bit 64 toggles per event.
REQ-006 SHALL have port joystick_0, input, 16: player 1 joystick.
REQ-007 SHALL have port joystick_1, input, 16: player 2 joystick.
REQ-008 SHALL have port orient, input, 1: 0 = vertical, 1 = horizontal remap.
REQ-009 SHALL have port in0_reg, output, 8: active-low {2'b00, coin, 1'b0, down, right, left, up}.
REQ-010 SHALL have port in1_reg, output, 8: active-low {1'b0, start2, start1, 5'b00000}.

Function
REQ-011 SHALL register ps2_key[64] each cycle; a key event occurs when the registered copy differs from the live bit.
REQ-012 SHALL derive pressed = (ps2_key[15:8] != 8'hF0).
REQ-013 SHALL derive extended = ps2_key[23:16]==8'hE0 on release, ps2_key[15:8]==8'hE0 on press.
REQ-014 SHALL force the 9-bit code {extended, ps2_key[7:0]} to 0 when ps2_key[63:24] is nonzero; code 0 matches no key.
REQ-015 SHALL, on an event, set the matching button register to pressed: X75 up, X72 down, X6B left, X74 right (extended ignored); 029 and 006 start2; 014 and 005 start1; 004 coin; all other registers hold.
REQ-016 SHALL combine joy = joystick_0 | joystick_1.
REQ-017 SHALL, with orient=0, derive up=btn_up|joy[3], down=btn_down|joy[2], left=btn_left|joy[1], right=btn_right|joy[0].
REQ-018 SHALL, with orient=1, derive up=btn_left|joy[1], down=btn_right|joy[0], left=btn_down|joy[2], right=btn_up|joy[3].
REQ-019 SHALL derive start1=btn_start1|joy[4], start2=btn_start2|joy[5], coin_raw=btn_coin|joy[6].
REQ-020 SHALL register in0_reg and in1_reg; key event in cycle N gives button register in N+1 and outputs in N+2; joystick change gives outputs 1 cycle later.
REQ-021 SHALL drive orient changes through to the outputs on the next cycle, with no event needed.

Reset
REQ-022 SHALL, while reset=1, clear all button registers, put the coin FSM in IDLE, clear its counter and drive in0_reg=8'hFF, in1_reg=8'hFF.
REQ-023 SHALL load the ps2_key[64] copy from the live bit during reset so no event fires on release; reset aborts any coin pulse in progress.

Configuration
REQ-024 SHALL, with COIN_PULSE_EN defined, shape coin with an FSM IDLE->PULSE->HOLDOFF->IDLE.
REQ-025 SHALL, in IDLE, move to PULSE on a rising edge of registered coin_raw, asserting coin.
REQ-026 SHALL, in PULSE, count ce_6m ticks and move to HOLDOFF after COIN_TICKS ticks, deasserting coin.
REQ-027 SHALL, in HOLDOFF, count COIN_TICKS ticks and return to IDLE; edges in PULSE/HOLDOFF are ignored; a held coin_raw does not retrigger.
REQ-028 SHALL, with COIN_PULSE_EN undefined, drive coin = coin_raw registered, with no FSM or counter.

Structure
REQ-029 SHALL take key code constants (9-bit) and the coin state enum from package arcade_input_pkg.
REQ-030 SHALL place the coin FSM in a single sub-module, coin_pulse, instantiated only under COIN_PULSE_EN.

Verification
REQ-031 SHALL test key 0x75 press, toggle bit 64 -> in0_reg=8'hFE two cycles later; event with ps2_key[15:8]=F0 -> 8'hFF.
REQ-032 SHALL test orient=1 with joystick_0[1]=1 -> in0_reg=8'hFE; orient=0 with the same input -> 8'hFD.
REQ-033 SHALL test ps2_key[63:24]=nonzero with code 0x05 -> in1_reg stays 8'hFF; valid 0x05 press -> 8'hDF.
REQ-034 SHALL test, under COIN_PULSE_EN with COIN_TICKS=4, joystick_0[6] held -> in0 bit5 low for 4 ce ticks then high; no retrigger while held; retrigger after release and HOLDOFF.
REQ-035 SHALL test reset asserted mid-PULSE -> in0_reg=8'hFF next cycle; no event fires after reset release with bit 64 unchanged.
